// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - constants, state encoding and feedback helper shared by the LFSR checker and generator
package lfsr_pkg;

  localparam int LFSR_W = 26;

  localparam int TAP_A = 25;
  localparam int TAP_B = 5;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] TAP_MASK =
    (LFSR_W'(1) << TAP_A) | (LFSR_W'(1) << TAP_B) |
    (LFSR_W'(1) << TAP_C) | (LFSR_W'(1) << TAP_D);

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } state_e;

  // Next bit of x^26+x^6+x^2+x+1 with sh[0] holding the newest bit.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] sh);
    return ^(sh & TAP_MASK);
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational LFSR feedback: predicted bit and the shifted-in next state
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] sh_i,
  output logic              fb_o,
  output logic [LFSR_W-1:0] nxt_o
);

  assign fb_o  = lfsr_fb(sh_i);
  assign nxt_o = {sh_i[LFSR_W-2:0], fb_o};

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - 26-bit LFSR sequence checker with lock FSM and windowed loss-of-lock
// Optional saturating error counter and cnt_clr are built only when LFSR_CHECKER_CNT_EN is defined.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int ERR_THRESH = 4,
  parameter int WINDOW     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_vld,
  input  logic        din,
  input  logic        cnt_clr,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt
);

  localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WEW = $clog2(ERR_THRESH + 1);
  localparam logic [4:0] FILL_FULL = 5'(LFSR_W);

  state_e            state_q;
  logic [LFSR_W-1:0] sh_q;
  logic [4:0]        fcnt_q;
  logic [WCW-1:0]    win_cnt_q;
  logic [WEW-1:0]    win_err_q;
  logic              err_q;

  logic              pred;
  logic [LFSR_W-1:0] sh_pred;
  logic              mism;
  logic [WEW-1:0]    win_err_d;

  lfsr_next u_next (
    .sh_i  (sh_pred_src()),
    .fb_o  (pred),
    .nxt_o (sh_pred)
  );

  function automatic logic [LFSR_W-1:0] sh_pred_src();
    return sh_q;
  endfunction

  always_comb begin
    mism      = din_vld && (state_q == CHECK) && (din != pred);
    win_err_d = win_err_q + WEW'(mism);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      sh_q      <= '0;
      fcnt_q    <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= mism;
      if (din_vld) begin
        case (state_q)
          HUNT: begin
            sh_q <= {sh_q[LFSR_W-2:0], din};
            // A full register of zeros is the lock-up state; refill rather than lock.
            if (fcnt_q == FILL_FULL) begin
              fcnt_q <= '0;
              if (sh_q != '0) state_q <= CHECK;
            end else begin
              fcnt_q <= fcnt_q + 5'd1;
            end
          end
          CHECK: begin
            sh_q <= sh_pred;
            // The error on this bit counts before a coincident window wrap.
            if (win_err_d >= WEW'(ERR_THRESH)) begin
              state_q   <= HUNT;
              fcnt_q    <= '0;
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else if (win_cnt_q == WCW'(WINDOW - 1)) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + WCW'(1);
              win_err_q <= win_err_d;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign locked = (state_q == CHECK);
  assign err    = err_q;

`ifdef LFSR_CHECKER_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (mism && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign err_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker driven by a seeded 26-bit generator
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_vld;
  logic        din;
  logic        cnt_clr;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  lfsr_checker #(
    .ERR_THRESH (4),
    .WINDOW     (64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din_vld (din_vld),
    .din     (din),
    .cnt_clr (cnt_clr),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt)
  );

`ifdef LFSR_CHECKER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [4:0]  fcnt;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [25:0] gen;
  logic        m_locked;
  logic        m_err;
  logic [25:0] m_hist;
  int          m_fill;
  int          m_wcnt;
  int          m_werr;
  int          m_cnt;

  int vbits;
  int lock_at;
  int n_err;
  int seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_cnt(input int n);
    return CNT_EN ? n : 0;
  endfunction

  task automatic model_update(input logic r, input logic v, input logic d,
                              input logic flip, input logic clr);
    if (r) begin
      m_locked = 1'b0; m_err = 1'b0; m_hist = '0;
      m_fill = 0; m_wcnt = 0; m_werr = 0; m_cnt = 0;
    end else begin
      m_err = 1'b0;
      if (v) begin
        if (!m_locked) begin
          if (m_fill == 26) begin
            m_fill = 0;
            if (m_hist != '0) m_locked = 1'b1;
          end else begin
            m_fill++;
          end
          m_hist = {m_hist[24:0], d};
        end else begin
          m_err = flip;
          if (m_werr + int'(flip) >= 4) begin
            m_locked = 1'b0; m_wcnt = 0; m_werr = 0; m_fill = 0;
          end else if (m_wcnt == 63) begin
            m_wcnt = 0; m_werr = 0;
          end else begin
            m_wcnt++;
            m_werr += int'(flip);
          end
        end
      end
      if (clr) m_cnt = 0;
      else if (m_err && m_cnt != 65535) m_cnt++;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic flip,
                      input logic clr, input logic zero_data);
    logic tb;
    logic d;
    exp_t e;
    @(negedge clk);
    tb = 1'b0;
    if (v && !zero_data) begin
      tb  = gen[25] ^ gen[5] ^ gen[1] ^ gen[0];
      gen = {gen[24:0], tb};
    end
    d       = zero_data ? 1'b0 : (tb ^ flip);
    rst     = r;
    din_vld = v;
    din     = v ? d : 1'($urandom_range(0, 1));
    cnt_clr = clr;
    model_update(r, v, d, flip, clr);
    e.locked = m_locked;
    e.err    = m_err;
    e.cnt    = 16'(exp_cnt(m_cnt));
    e.fcnt   = 5'(m_fill);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("locked", 32'(locked), 32'(e.locked));
    check("err", 32'(err), 32'(e.err));
    check("err_cnt", 32'(err_cnt), 32'(e.cnt));
    check("fcnt", 32'(dut.fcnt_q), 32'(e.fcnt));
  endtask

  initial begin
    rst = 1'b1; din_vld = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    gen = 26'h2AA5C81;
    model_update(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_cnt", 32'(err_cnt), 32'd0);

    // Clean contiguous stream
    vbits = 0; lock_at = -1;
    for (int i = 0; i < 1000; i++) begin
      step(0, 1, 0, 0, 0);
      vbits++;
      if (locked && lock_at < 0) lock_at = vbits;
    end
    check("lock_latency", 32'(lock_at), 32'd27);
    check("clean_cnt", 32'(err_cnt), 32'd0);
    check("clean_locked", 32'(locked), 32'd1);

    // Three isolated errors ten bits apart
    n_err = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 1, (i % 10 == 0), 0, 0);
      if (err) n_err++;
    end
    check("iso_pulses", 32'(n_err), 32'd3);
    check("iso_cnt", 32'(err_cnt), 32'(exp_cnt(3)));
    check("iso_locked", 32'(locked), 32'd1);

    for (int i = 0; i < 128; i++) step(0, 1, 0, 0, 0);
    for (int g = 0; g < 100 && m_wcnt != 0; g++) step(0, 1, 0, 0, 0);

    // Four errors inside one window force loss of lock
    for (int i = 0; i < 16; i++) step(0, 1, (i % 5 == 0), 0, 0);
    check("burst_unlock", 32'(locked), 32'd0);
    check("burst_cnt", 32'(err_cnt), 32'(exp_cnt(7)));
    vbits = 0; lock_at = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, 0, 0);
      vbits++;
      if (locked && lock_at < 0) lock_at = vbits;
    end
    check("relock_latency", 32'(lock_at), 32'd27);

    step(0, 0, 0, 1, 0);
    check("clr_cnt", 32'(err_cnt), 32'd0);
    check("clr_locked", 32'(locked), 32'd1);

    // All-zero input never locks; fill counter restarts after reaching 26
    step(1, 0, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, 0, 1);
      if (locked) seen++;
    end
    check("zero_nolock", 32'(seen), 32'd0);
    check("zero_fcnt", 32'(dut.fcnt_q), 32'd13);

    // Gapped stream: every other cycle plus random extra gaps
    step(1, 0, 0, 0, 0);
    vbits = 0; lock_at = -1; n_err = 0;
    for (int c = 0; c < 1000 && vbits < 100; c++) begin
      logic v;
      logic f;
      v = (c % 2 == 0) && ($urandom_range(0, 3) != 0);
      f = v && ((vbits + 1 == 60) || (vbits + 1 == 70) || (vbits + 1 == 80));
      step(0, v, f, 0, 0);
      if (v) vbits++;
      if (locked && lock_at < 0) lock_at = vbits;
      if (err) n_err++;
    end
    check("gap_bits", 32'(vbits), 32'd100);
    check("gap_lock_latency", 32'(lock_at), 32'd27);
    check("gap_pulses", 32'(n_err), 32'd3);
    check("gap_cnt", 32'(err_cnt), 32'(exp_cnt(3)));

    for (int i = 0; i < 100; i++) step(0, 1, (i == 20 || i == 60), 0, 0);
    check("five_cnt", 32'(err_cnt), 32'(exp_cnt(5)));
    check("five_locked", 32'(locked), 32'd1);

    // Reset while locked discards everything
    step(1, 1, 0, 0, 0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);

    for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    check("clr_err_pulse", 32'(err), 32'd1);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_err_locked", 32'(locked), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
